// File: rtl/serdes_pkg.sv
// Shared definitions for the 10-bit comma/8b10b serdes path (TX encoder and RX aligner).
package serdes_pkg;

    localparam int SYM_BITS = 10;

    // K28.5 comma prefixes as they sit in sr[6:0] (sr[0] = oldest bit).
    localparam logic [6:0] COMMA_P7 = 7'b1111100;
    localparam logic [6:0] COMMA_N7 = 7'b0000011;

    typedef enum logic [1:0] {
        HUNT,
        CHECK,
        LOCKED
    } align_state_t;

    // Symbol phase counter step, wrapping after the last bit of a symbol.
    function automatic logic [3:0] phase_next(input logic [3:0] ph);
        return (ph == 4'(SYM_BITS - 1)) ? 4'd0 : ph + 4'd1;
    endfunction

endpackage

// File: rtl/comma_aligner_10b_if.sv
// Serial-in / aligned-symbol-out bundle between the line side and the 8b10b decoder.
interface comma_aligner_10b_if;
    import serdes_pkg::*;

    logic                serial_in;
    logic [SYM_BITS-1:0] sym_out;
    logic                sym_valid;
    logic                sym_is_comma;
    logic                locked;
    logic                align_err;

    modport master (
        output serial_in,
        input  sym_out, sym_valid, sym_is_comma, locked, align_err
    );

    modport slave (
        input  serial_in,
        output sym_out, sym_valid, sym_is_comma, locked, align_err
    );

endinterface

// File: rtl/comma_aligner_10b_comma_detect.sv
// Combinational K28.5 comma detector over a 10-bit receive window (bit 0 oldest).
module comma_detect
    import serdes_pkg::*;
(
    input  logic [SYM_BITS-1:0] window,
    output logic                is_comma
);

    // Only the 7-bit comma prefix decides; the tail of the symbol is don't-care.
    logic unused_tail;
    assign unused_tail = ^window[SYM_BITS-1:7];

    assign is_comma = (window[6:0] == COMMA_P7) || (window[6:0] == COMMA_N7);

endmodule

// File: rtl/comma_aligner_10b.sv
// RX comma aligner: finds K28.5 boundaries in the serial stream, runs the
// hunt/check/locked state machine and emits word-aligned 10-bit symbols.
module comma_aligner_10b
    import serdes_pkg::*;
#(
    parameter int LOCK_COMMAS    = 3,
    parameter int MISALIGN_LIMIT = 2,
    parameter int COMMA_TIMEOUT  = 32
) (
    input logic               clk,
    input logic               rst,
    comma_aligner_10b_if.slave bus
);

    localparam int GOOD_W = $clog2(LOCK_COMMAS + 1);
    localparam int MIS_W  = $clog2(MISALIGN_LIMIT + 1);
    localparam int TMR_W  = $clog2(COMMA_TIMEOUT + 1);

    // Saturating increment toward a limit; counters never wrap.
    function automatic int sat_inc(input int val, input int limit);
        return (val >= limit) ? limit : val + 1;
    endfunction

    logic [SYM_BITS-1:0] sr;
    logic [3:0]          ph;
    align_state_t        state;
    logic [GOOD_W-1:0]   good_cnt;
    logic [MIS_W-1:0]    mis_cnt;
    logic [TMR_W-1:0]    timer;
    logic                is_comma;

    logic [GOOD_W-1:0]   good_inc;
    logic [MIS_W-1:0]    mis_inc;
    logic [TMR_W-1:0]    timer_inc;
    logic                good_full;
    logic                mis_full;
    logic                timer_full;
    logic                boundary;

    comma_detect u_detect (
        .window   (sr),
        .is_comma (is_comma)
    );

    assign boundary   = (ph == 4'd0);
    assign good_inc   = GOOD_W'(sat_inc(int'(good_cnt), LOCK_COMMAS));
    assign mis_inc    = MIS_W'(sat_inc(int'(mis_cnt), MISALIGN_LIMIT));
    assign timer_inc  = TMR_W'(sat_inc(int'(timer), COMMA_TIMEOUT));
    assign good_full  = (int'(good_inc) >= LOCK_COMMAS);
    assign mis_full   = (int'(mis_inc) >= MISALIGN_LIMIT);
    assign timer_full = (int'(timer_inc) >= COMMA_TIMEOUT);

    // Receive shift register: newest bit enters at the top, oldest sits in sr[0].
    always_ff @(posedge clk) begin
        if (rst) begin
            sr <= '0;
        end else begin
            sr <= {bus.serial_in, sr[SYM_BITS-1:1]};
        end
    end

    // Alignment state machine with phase tracking, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= HUNT;
            ph               <= 4'd0;
            good_cnt         <= '0;
            mis_cnt          <= '0;
            timer            <= '0;
            bus.sym_out      <= '0;
            bus.sym_valid    <= 1'b0;
            bus.sym_is_comma <= 1'b0;
            bus.locked       <= 1'b0;
            bus.align_err    <= 1'b0;
        end else begin
            ph            <= phase_next(ph);
            bus.sym_valid <= 1'b0;
            bus.align_err <= 1'b0;
            unique case (state)
                HUNT: begin
                    if (is_comma) begin
                        // This cycle becomes the boundary, so the next phase is 1.
                        ph       <= 4'd1;
                        good_cnt <= GOOD_W'(1);
                        timer    <= '0;
                        if (LOCK_COMMAS == 1) begin
                            state      <= LOCKED;
                            bus.locked <= 1'b1;
                        end else begin
                            state <= CHECK;
                        end
                    end
                end
                CHECK: begin
                    if (is_comma && boundary) begin
                        good_cnt <= good_inc;
                        timer    <= '0;
                        mis_cnt  <= '0;
                        if (good_full) begin
                            state      <= LOCKED;
                            bus.locked <= 1'b1;
                        end
                    end else if (is_comma) begin
                        // Off-boundary comma restarts the count at the new phase.
                        bus.align_err <= 1'b1;
                        ph            <= 4'd1;
                        good_cnt      <= GOOD_W'(1);
                        timer         <= '0;
                    end else if (boundary) begin
                        timer <= timer_inc;
                        if (timer_full) begin
                            state <= HUNT;
                        end
                    end
                end
                LOCKED: begin
                    if (boundary) begin
                        bus.sym_out      <= sr;
                        bus.sym_is_comma <= is_comma;
                        bus.sym_valid    <= 1'b1;
                    end
                    if (is_comma && boundary) begin
                        timer   <= '0;
                        mis_cnt <= '0;
                    end else if (is_comma) begin
                        // Tolerate isolated slips; alignment stays until the limit.
                        bus.align_err <= 1'b1;
                        mis_cnt       <= mis_inc;
                        if (mis_full) begin
                            state      <= HUNT;
                            bus.locked <= 1'b0;
                        end
                    end else if (boundary) begin
                        timer <= timer_inc;
                        if (timer_full) begin
                            state      <= HUNT;
                            bus.locked <= 1'b0;
                        end
                    end
                end
                default: begin
                    state      <= HUNT;
                    bus.locked <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_comma_aligner_10b.sv
// Bench for comma_aligner_10b: directed frame sequences plus randomized traffic,
// every cycle compared against a bit-history reference model.
module tb_comma_aligner_10b;
    import serdes_pkg::*;

    localparam int LOCK_COMMAS    = 3;
    localparam int MISALIGN_LIMIT = 2;
    localparam int COMMA_TIMEOUT  = 32;
    localparam logic [9:0] COMMA_RDN = 10'h17C; // first-received 0011111010
    localparam logic [9:0] COMMA_RDP = 10'h283; // first-received 1100000101
    localparam int M_HUNT = 0, M_CHECK = 1, M_LOCKED = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    comma_aligner_10b_if bus ();

    comma_aligner_10b #(
        .LOCK_COMMAS    (LOCK_COMMAS),
        .MISALIGN_LIMIT (MISALIGN_LIMIT),
        .COMMA_TIMEOUT  (COMMA_TIMEOUT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [9:0] sym_in;
        logic [9:0] exp_sym;
        logic       exp_comma;
    } vec_t;

    vec_t vecs[8];
    int total = 0;
    int bad   = 0;
    int err_seen = 0;
    logic [10:0] got[$];

    // Reference model state: absolute cycle index and the cycle chosen as boundary.
    int m_win[10];
    int m_mode = M_HUNT;
    int m_cur = 0, m_anchor = 0;
    int m_good = 0, m_mis = 0, m_timer = 0;
    logic e_valid = 0, e_comma = 0, e_locked = 0, e_err = 0;
    logic [9:0] e_sym = '0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_is_comma();
        bit p = 1, n = 1;
        for (int i = 0; i < 7; i++) begin
            int want;
            want = (i < 2) ? 0 : 1;
            if (m_win[i] != want) p = 0;
            if (m_win[i] != 1 - want) n = 0;
        end
        return p || n;
    endfunction

    task automatic model_step(input bit b, input bit r);
        bit com, bnd;
        if (r) begin
            m_mode = M_HUNT;
            for (int i = 0; i < 10; i++) m_win[i] = 0;
            m_good = 0; m_mis = 0; m_timer = 0;
            e_valid = 0; e_comma = 0; e_locked = 0; e_err = 0; e_sym = '0;
            m_cur++;
            m_anchor = m_cur;
        end else begin
            com = m_is_comma();
            bnd = ((m_cur - m_anchor) % 10) == 0;
            e_valid = 0;
            e_err = 0;
            if (m_mode == M_HUNT) begin
                if (com) begin
                    m_anchor = m_cur; m_good = 1; m_timer = 0;
                    m_mode = (LOCK_COMMAS == 1) ? M_LOCKED : M_CHECK;
                end
            end else if (m_mode == M_CHECK) begin
                if (com && bnd) begin
                    m_good++; m_timer = 0; m_mis = 0;
                    if (m_good >= LOCK_COMMAS) m_mode = M_LOCKED;
                end else if (com) begin
                    e_err = 1; m_anchor = m_cur; m_good = 1; m_timer = 0;
                end else if (bnd) begin
                    m_timer++;
                    if (m_timer >= COMMA_TIMEOUT) m_mode = M_HUNT;
                end
            end else begin
                if (bnd) begin
                    e_valid = 1; e_comma = com;
                    for (int i = 0; i < 10; i++) e_sym[i] = m_win[i][0];
                end
                if (com && bnd) begin
                    m_timer = 0; m_mis = 0;
                end else if (com) begin
                    e_err = 1; m_mis++;
                    if (m_mis >= MISALIGN_LIMIT) m_mode = M_HUNT;
                end else if (bnd) begin
                    m_timer++;
                    if (m_timer >= COMMA_TIMEOUT) m_mode = M_HUNT;
                end
            end
            e_locked = (m_mode == M_LOCKED);
            for (int i = 0; i < 9; i++) m_win[i] = m_win[i+1];
            m_win[9] = int'(b);
            m_cur++;
        end
    endtask

    task automatic send_bit(input bit b);
        bus.serial_in = b;
        @(posedge clk);
        model_step(b, rst);
        #1;
        check("locked", int'(bus.locked), int'(e_locked));
        check("sym_valid", int'(bus.sym_valid), int'(e_valid));
        check("align_err", int'(bus.align_err), int'(e_err));
        if (e_valid) begin
            check("sym_out", int'(bus.sym_out), int'(e_sym));
            check("sym_is_comma", int'(bus.sym_is_comma), int'(e_comma));
        end
        if (bus.sym_valid) got.push_back({bus.sym_is_comma, bus.sym_out});
        if (bus.align_err) err_seen++;
    endtask

    task automatic send_sym(input logic [9:0] sym, input int nbits = 10);
        for (int i = 0; i < nbits; i++) send_bit(sym[i]);
    endtask

    task automatic send_frame_rest();
        for (int k = 1; k < 8; k++) send_sym(vecs[k].sym_in);
    endtask

    task automatic send_frame();
        send_sym(vecs[0].sym_in);
        send_frame_rest();
    endtask

    // One extra bit before the comma, one bit dropped at the end: net phase unchanged.
    task automatic send_slip_frame();
        send_bit(1'b1);
        send_sym(vecs[0].sym_in);
        for (int k = 1; k < 7; k++) send_sym(vecs[k].sym_in);
        send_sym(vecs[7].sym_in, 9);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        send_bit(1'b0);
        rst = 1'b0;
    endtask

    // Captured symbols should be the 7 data words followed by the next comma.
    task automatic check_table(input string tag);
        check({tag, "_count"}, int'(got.size() >= 8), 1);
        for (int k = 0; k < 8 && k < got.size(); k++) begin
            int idx;
            idx = (k + 1) % 8;
            check($sformatf("%s_sym%0d", tag, k), int'(got[k][9:0]), int'(vecs[idx].exp_sym));
            check($sformatf("%s_comma%0d", tag, k), int'(got[k][10]), int'(vecs[idx].exp_comma));
        end
    endtask

    function automatic logic [9:0] rand_data();
        if ($urandom_range(0, 99) < 85) return vecs[$urandom_range(1, 7)].sym_in;
        return 10'($urandom_range(0, 1023));
    endfunction

    initial begin
        vecs[0] = '{COMMA_RDN, COMMA_RDN, 1'b1};
        vecs[1] = '{10'h2AA, 10'h2AA, 1'b0};
        vecs[2] = '{10'h155, 10'h155, 1'b0};
        vecs[3] = '{10'h333, 10'h333, 1'b0};
        vecs[4] = '{10'h0CC, 10'h0CC, 1'b0};
        vecs[5] = '{10'h366, 10'h366, 1'b0};
        vecs[6] = '{10'h199, 10'h199, 1'b0};
        vecs[7] = '{10'h2D2, 10'h2D2, 1'b0};

        bus.serial_in = 1'b0;
        do_reset();
        check("reset_sym_out", int'(bus.sym_out), 0);
        check("reset_valid", int'(bus.sym_valid), 0);
        check("reset_comma", int'(bus.sym_is_comma), 0);
        check("reset_locked", int'(bus.locked), 0);
        check("reset_err", int'(bus.align_err), 0);

        // Idle line: nothing must lock or strobe.
        err_seen = 0; got.delete();
        repeat (500) send_bit(1'b0);
        check("idle_valid_count", got.size(), 0);
        check("idle_err_count", err_seen, 0);
        check("idle_locked", int'(bus.locked), 0);

        // Frames with a 3-bit lead-in offset.
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        send_frame(); send_frame();
        send_sym(vecs[0].sym_in);
        check("lock_before", int'(bus.locked), 0);
        got.delete();
        for (int i = 0; i < 10; i++) begin
            send_bit(vecs[1].sym_in[i]);
            if (i == 0) check("lock_rise", int'(bus.locked), 1);
        end
        for (int k = 2; k < 8; k++) send_sym(vecs[k].sym_in);
        send_frame();
        check_table("lock");

        // Bit slip: first slipped comma tolerated, second drops lock, then re-lock.
        err_seen = 0;
        send_bit(1'b1); send_frame();
        check("slip1_err", err_seen, 1);
        check("slip1_locked", int'(bus.locked), 1);
        err_seen = 0;
        send_frame();
        check("slip2_err", err_seen, 1);
        check("slip2_locked", int'(bus.locked), 0);
        send_frame(); send_frame();
        check("slip_hunting", int'(bus.locked), 0);
        send_sym(vecs[0].sym_in);
        got.delete();
        send_frame_rest(); send_frame();
        check("slip_relocked", int'(bus.locked), 1);
        check_table("relock");

        // Comma timeout while locked.
        send_sym(vecs[0].sym_in);
        got.delete();
        for (int n = 0; n < 32; n++) send_sym(vecs[1 + n % 7].sym_in);
        check("to_locked_at32", int'(bus.locked), 1);
        for (int i = 0; i < 10; i++) begin
            send_bit(vecs[5].sym_in[i]);
            if (i == 0) begin
                check("to_locked_fall", int'(bus.locked), 0);
                check("to_valid_32", int'(bus.sym_valid), 1);
            end
        end
        send_sym(vecs[6].sym_in);
        check("to_emit_count", got.size(), 33);
        send_frame(); send_frame(); send_frame();
        check("to_relock", int'(bus.locked), 1);

        // Single slip followed by an aligned comma clears the misalign count.
        err_seen = 0;
        send_slip_frame();
        check("off_err", err_seen, 1);
        check("off_locked", int'(bus.locked), 1);
        err_seen = 0;
        send_frame();
        check("aligned_err", err_seen, 0);
        check("aligned_locked", int'(bus.locked), 1);
        err_seen = 0;
        send_slip_frame();
        check("late_slip_err", err_seen, 1);
        check("late_slip_locked", int'(bus.locked), 1);
        send_frame();
        check("late_aligned_locked", int'(bus.locked), 1);

        // Reset in the middle of a locked frame.
        send_sym(vecs[0].sym_in); send_sym(vecs[1].sym_in); send_sym(vecs[2].sym_in);
        do_reset();
        check("midrst_locked", int'(bus.locked), 0);
        check("midrst_valid", int'(bus.sym_valid), 0);
        send_frame(); send_frame();
        check("midrst_two_commas", int'(bus.locked), 0);
        send_frame();
        check("midrst_relock", int'(bus.locked), 1);

        // Randomized traffic: slips, drops, resets, long gaps, both disparities.
        for (int f = 0; f < 250; f++) begin
            int r;
            bit drop;
            r = $urandom_range(0, 99);
            drop = 1'b0;
            if (r < 4) send_bit(1'($urandom_range(0, 1)));
            else if (r < 8) drop = 1'b1;
            else if (r < 11) do_reset();
            else if (r < 15) repeat ($urandom_range(25, 40)) send_sym(rand_data());
            if (r >= 15 && r < 20) send_sym(rand_data());
            else send_sym(($urandom_range(0, 1) == 0) ? COMMA_RDN : COMMA_RDP);
            for (int k = 1; k < 8; k++) begin
                if (drop && k == 7) send_sym(rand_data(), 9);
                else send_sym(rand_data());
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
